// File: rtl/twi_responder_if.sv
// twi_responder_if: open-drain TWI pad lines between the bus master (or pad model) and the target.
interface twi_responder_if;
  logic iScl;
  logic iSda;
  logic oSdaLow;

  modport slave (input iScl, input iSda, output oSdaLow);
  modport master (output iScl, output iSda, input oSdaLow);
endinterface

// File: rtl/twi_responder.sv
// twi_responder: TWI (I2C) target serving a byte-wide register file with an auto-incrementing pointer.
// Optional SCL stuck-low recovery is enabled by defining TWI_RESPONDER_TIMEOUT_EN.
module twi_responder #(
  parameter logic [6:0] DEV_ADDR       = 7'h76,
  parameter int         NUM_REGS       = 16,
  parameter int         FILTER_LEN     = 3,
  parameter int         TIMEOUT_CYCLES = 65535,
  localparam int        PW             = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  twi_responder_if.slave        twiBus,
  input  logic                  iLocalWrEn,
  input  logic [PW-1:0]         iLocalAddr,
  input  logic [7:0]            iLocalData,
  output logic [NUM_REGS*8-1:0] oRegs,
  output logic                  oWrStrobe,
  output logic [PW-1:0]         oWrAddr,
  output logic [7:0]            oWrData,
  output logic                  oBusy
);
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WRITE     = 4'd5;
  localparam logic [3:0] WRITE_ACK = 4'd6;
  localparam logic [3:0] READ      = 4'd7;
  localparam logic [3:0] READ_ACK  = 4'd8;
  localparam logic [3:0] IGNORE    = 4'd9;

  // Index 1 is SCL, index 0 is SDA throughout the conditioning path.
  logic [1:0]     sync1_r, sync2_r, filt_r, prev_r;
  logic [FCW-1:0] fltCnt_r [2];

  logic [3:0]            state_r;
  logic [3:0]            bitCnt_r;
  logic [7:0]            shift_r, txShift_r;
  logic [PW-1:0]         ptr_r;
  logic                  rw_r, mAck_r;
  logic [NUM_REGS*8-1:0] regs_r;
  logic                  sdaLow_r, busy_r, wrStrobe_r;
  logic [PW-1:0]         wrAddr_r;
  logic [7:0]            wrData_r;

  logic          sclF_s, sdaF_s, sclRise_s, sclFall_s, startEvt_s, stopEvt_s, toFire_s;
  logic [7:0]    rxByte_s, curReg_s;
  logic [PW-1:0] ptrNext_s;

  assign sclF_s     = filt_r[1];
  assign sdaF_s     = filt_r[0];
  assign sclRise_s  = sclF_s & ~prev_r[1];
  assign sclFall_s  = ~sclF_s & prev_r[1];
  assign startEvt_s = sclF_s & prev_r[1] & prev_r[0] & ~sdaF_s;
  assign stopEvt_s  = sclF_s & prev_r[1] & ~prev_r[0] & sdaF_s;
  assign rxByte_s   = {shift_r[6:0], sdaF_s};
  assign curReg_s   = regs_r[ptr_r*8 +: 8];
  assign ptrNext_s  = (ptr_r == PW'(NUM_REGS - 1)) ? '0 : ptr_r + PW'(1);

  // Synchronize SCL/SDA and accept a new level only after FILTER_LEN matching samples.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
      filt_r  <= 2'b11;
      prev_r  <= 2'b11;
      for (int i = 0; i < 2; i++) fltCnt_r[i] <= '0;
    end else begin
      sync1_r <= {twiBus.iScl, twiBus.iSda};
      sync2_r <= sync1_r;
      prev_r  <= filt_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          fltCnt_r[i] <= '0;
        end else if (fltCnt_r[i] == FCW'(FILTER_LEN - 1)) begin
          filt_r[i]   <= sync2_r[i];
          fltCnt_r[i] <= '0;
        end else begin
          fltCnt_r[i] <= fltCnt_r[i] + FCW'(1);
        end
      end
    end
  end

`ifdef TWI_RESPONDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] toCnt_r;
  logic          active_s;

  assign active_s = (state_r != IDLE) && (state_r != IGNORE);
  assign toFire_s = active_s && !sclF_s && (toCnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive SCL-low cycles while a transfer is in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      toCnt_r <= '0;
    end else if (!active_s || sclF_s || toFire_s) begin
      toCnt_r <= '0;
    end else begin
      toCnt_r <= toCnt_r + TW'(1);
    end
  end
`else
  assign toFire_s = 1'b0;
`endif

  // Protocol FSM, register file and bus-write reporting; the bus write is last so it wins a collision.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r    <= IDLE;
      bitCnt_r   <= 4'd0;
      shift_r    <= 8'd0;
      txShift_r  <= 8'd0;
      ptr_r      <= '0;
      rw_r       <= 1'b0;
      mAck_r     <= 1'b0;
      regs_r     <= '0;
      sdaLow_r   <= 1'b0;
      busy_r     <= 1'b0;
      wrStrobe_r <= 1'b0;
      wrAddr_r   <= '0;
      wrData_r   <= 8'd0;
    end else begin
      wrStrobe_r <= 1'b0;
      if (iLocalWrEn && (int'(iLocalAddr) < NUM_REGS)) regs_r[iLocalAddr*8 +: 8] <= iLocalData;

      if (stopEvt_s || toFire_s) begin
        state_r  <= IDLE;
        sdaLow_r <= 1'b0;
        busy_r   <= 1'b0;
      end else if (startEvt_s) begin
        state_r  <= ADDR;
        bitCnt_r <= 4'd0;
        sdaLow_r <= 1'b0;
      end else begin
        case (state_r)
          ADDR, PTR, WRITE: begin
            if (sclRise_s) begin
              shift_r  <= rxByte_s;
              bitCnt_r <= bitCnt_r + 4'd1;
              if (state_r == WRITE && bitCnt_r == 4'd7) begin
                regs_r[ptr_r*8 +: 8] <= rxByte_s;
                wrStrobe_r <= 1'b1;
                wrAddr_r   <= ptr_r;
                wrData_r   <= rxByte_s;
              end
            end else if (sclFall_s && bitCnt_r == 4'd8) begin
              bitCnt_r <= 4'd0;
              if (state_r == ADDR) begin
                if (shift_r[7:1] == DEV_ADDR) begin
                  state_r  <= ADDR_ACK;
                  sdaLow_r <= 1'b1;
                  busy_r   <= 1'b1;
                  rw_r     <= shift_r[0];
                end else begin
                  state_r <= IGNORE;
                end
              end else if (state_r == PTR) begin
                if (int'(shift_r) < NUM_REGS) begin
                  ptr_r    <= shift_r[PW-1:0];
                  state_r  <= PTR_ACK;
                  sdaLow_r <= 1'b1;
                end else begin
                  state_r <= IGNORE;
                end
              end else begin
                state_r  <= WRITE_ACK;
                sdaLow_r <= 1'b1;
              end
            end
          end
          ADDR_ACK: begin
            if (sclFall_s) begin
              bitCnt_r <= 4'd0;
              if (rw_r) begin
                state_r   <= READ;
                txShift_r <= curReg_s;
                sdaLow_r  <= ~curReg_s[7];
              end else begin
                state_r  <= PTR;
                sdaLow_r <= 1'b0;
              end
            end
          end
          PTR_ACK: begin
            if (sclFall_s) begin
              state_r  <= WRITE;
              sdaLow_r <= 1'b0;
            end
          end
          WRITE_ACK: begin
            if (sclFall_s) begin
              ptr_r    <= ptrNext_s;
              state_r  <= WRITE;
              sdaLow_r <= 1'b0;
            end
          end
          READ: begin
            if (sclRise_s) begin
              bitCnt_r <= bitCnt_r + 4'd1;
            end else if (sclFall_s) begin
              // The pointer advances once per byte sent, whatever the master answers.
              if (bitCnt_r == 4'd8) begin
                state_r  <= READ_ACK;
                sdaLow_r <= 1'b0;
                ptr_r    <= ptrNext_s;
              end else begin
                txShift_r <= {txShift_r[6:0], 1'b0};
                sdaLow_r  <= ~txShift_r[6];
              end
            end
          end
          READ_ACK: begin
            if (sclRise_s) begin
              mAck_r <= ~sdaF_s;
            end else if (sclFall_s) begin
              bitCnt_r <= 4'd0;
              if (mAck_r) begin
                state_r   <= READ;
                txShift_r <= curReg_s;
                sdaLow_r  <= ~curReg_s[7];
              end else begin
                state_r <= IGNORE;
              end
            end
          end
          IDLE, IGNORE: begin
            sdaLow_r <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            sdaLow_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign twiBus.oSdaLow = sdaLow_r;
  assign oRegs          = regs_r;
  assign oWrStrobe      = wrStrobe_r;
  assign oWrAddr        = wrAddr_r;
  assign oWrData        = wrData_r;
  assign oBusy          = busy_r;
endmodule

// File: tb/tb_twi_responder.sv
// tb_twi_responder: directed TWI master with scoreboard queues for ACK/read bits and bus-write strobes.
module tb_twi_responder;
  localparam int H = 20;
  localparam int Q = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         mScl, mSda;
  logic         localEn;
  logic [3:0]   localAddr;
  logic [7:0]   localData;
  logic [127:0] regs;
  logic         wrStrobe;
  logic [3:0]   wrAddr;
  logic [7:0]   wrData;
  logic         busy;

  int   checks = 0;
  int   errors = 0;
  int   pullCount = 0;
  logic dutSlot = 1'b0;
  logic sdaQ [$];
  logic [11:0] wrQ [$];
  logic [7:0]  model [16];
  logic        expLow;
  logic [11:0] expWr;

  twi_responder_if twiBus();
  assign twiBus.iScl = mScl;
  assign twiBus.iSda = mSda & ~twiBus.oSdaLow;

  twi_responder #(.DEV_ADDR(7'h76), .NUM_REGS(16), .FILTER_LEN(3), .TIMEOUT_CYCLES(100)) dut (
    .iClk(clk), .iRst(rst), .twiBus(twiBus),
    .iLocalWrEn(localEn), .iLocalAddr(localAddr), .iLocalData(localData),
    .oRegs(regs), .oWrStrobe(wrStrobe), .oWrAddr(wrAddr), .oWrData(wrData), .oBusy(busy)
  );

  always #5 clk = ~clk;

  task automatic clkWait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] modelFlat();
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[k*8 +: 8] = model[k];
    return f;
  endfunction

  // Monitor: every slot where the target owns SDA is compared against the queued expectation.
  always @(posedge mScl) begin
    if (dutSlot) begin
      checks++;
      if (sdaQ.size() == 0) begin
        errors++;
        $display("FAIL sdaSlot: oSdaLow=%b with nothing expected", twiBus.oSdaLow);
      end else begin
        expLow = sdaQ.pop_front();
        if (twiBus.oSdaLow !== expLow) begin
          errors++;
          $display("FAIL sdaSlot: oSdaLow=%b, expected %b", twiBus.oSdaLow, expLow);
        end
      end
    end
  end

  // Monitor: each bus-write strobe is matched against the queued (addr,data) pair.
  always @(negedge clk) begin
    if (twiBus.oSdaLow === 1'b1) pullCount++;
    if (wrStrobe === 1'b1) begin
      checks++;
      if (wrQ.size() == 0) begin
        errors++;
        $display("FAIL wrStrobe: unexpected write addr=%0d data=%0h", wrAddr, wrData);
      end else begin
        expWr = wrQ.pop_front();
        if ({wrAddr, wrData} !== expWr) begin
          errors++;
          $display("FAIL wrStrobe: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   wrAddr, wrData, expWr[11:8], expWr[7:0]);
        end
      end
    end
  end

  task automatic startCond();
    mSda = 1'b1; clkWait(H);
    mScl = 1'b1; clkWait(H);
    mSda = 1'b0; clkWait(H);
    mScl = 1'b0; clkWait(Q);
  endtask

  task automatic stopCond();
    mSda = 1'b0; clkWait(H);
    mScl = 1'b1; clkWait(H);
    mSda = 1'b1; clkWait(H);
  endtask

  task automatic sendBit(input logic b);
    mSda = b; clkWait(Q);
    mScl = 1'b1; clkWait(H);
    mScl = 1'b0; clkWait(Q);
  endtask

  task automatic dutBit(input logic expPull);
    mSda = 1'b1;
    sdaQ.push_back(expPull);
    dutSlot = 1'b1;
    clkWait(Q);
    mScl = 1'b1; clkWait(H);
    mScl = 1'b0; dutSlot = 1'b0;
    clkWait(Q);
  endtask

  // With collide set, a local write of 0x77 to reg2 is placed on the cycle the bus write lands.
  task automatic writeByte(input logic [7:0] b, input logic expAck, input logic collide);
    for (int i = 7; i >= 0; i--) begin
      if (collide && i == 0) begin
        mSda = b[0]; clkWait(Q);
        mScl = 1'b1; clkWait(5);
        localEn = 1'b1; localAddr = 4'd2; localData = 8'h77;
        clkWait(1);
        localEn = 1'b0;
        clkWait(H - 6);
        mScl = 1'b0; clkWait(Q);
      end else begin
        sendBit(b[i]);
      end
    end
    dutBit(expAck);
  endtask

  task automatic readByte(input logic [7:0] expData, input logic ack);
    for (int i = 7; i >= 0; i--) dutBit(~expData[i]);
    sendBit(~ack);
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
    wrQ.push_back({a, d});
    model[a] = d;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; mScl = 1'b1; mSda = 1'b1;
    localEn = 1'b0; localAddr = 4'd0; localData = 8'd0;
    for (int k = 0; k < 16; k++) model[k] = 8'd0;
    clkWait(5);
    rst = 1'b0;
    clkWait(2);
    chk("resetSdaLow", twiBus.oSdaLow, 1'b0);
    chk("resetRegs", regs, 128'd0);
    chk("resetWr", {wrStrobe, wrAddr, wrData}, 13'd0);
    chk("resetBusy", busy, 1'b0);

    // Local write: no strobe expected.
    localEn = 1'b1; localAddr = 4'd5; localData = 8'hC3;
    clkWait(1);
    localEn = 1'b0;
    model[5] = 8'hC3;
    clkWait(2);
    chk("localWrite", regs, modelFlat());

    // Write regs 3,4.
    startCond();
    writeByte(8'hEC, 1'b1, 1'b0);
    writeByte(8'h03, 1'b1, 1'b0);
    busWrite(4'd3, 8'hA5); writeByte(8'hA5, 1'b1, 1'b0);
    busWrite(4'd4, 8'h5A); writeByte(8'h5A, 1'b1, 1'b0);
    chk("busyInWrite", busy, 1'b1);
    stopCond();
    chk("busyAfterStop", busy, 1'b0);
    chk("regs34", regs, modelFlat());

    // Read back through a repeated START; the follow-up read proves the pointer stopped at 5.
    startCond();
    writeByte(8'hEC, 1'b1, 1'b0);
    writeByte(8'h03, 1'b1, 1'b0);
    startCond();
    writeByte(8'hED, 1'b1, 1'b0);
    readByte(8'hA5, 1'b1);
    readByte(8'h5A, 1'b0);
    stopCond();
    startCond();
    writeByte(8'hED, 1'b1, 1'b0);
    readByte(8'hC3, 1'b0);
    stopCond();

    // Address mismatch.
    p0 = pullCount;
    startCond();
    writeByte(8'hEE, 1'b0, 1'b0);
    writeByte(8'h12, 1'b0, 1'b0);
    writeByte(8'h34, 1'b0, 1'b0);
    chk("busyMismatch", busy, 1'b0);
    stopCond();
    chk("noPullMismatch", pullCount - p0, 0);

    // Pointer wrap 15 -> 0.
    startCond();
    writeByte(8'hEC, 1'b1, 1'b0);
    writeByte(8'h0F, 1'b1, 1'b0);
    busWrite(4'd15, 8'h11); writeByte(8'h11, 1'b1, 1'b0);
    busWrite(4'd0, 8'h22);  writeByte(8'h22, 1'b1, 1'b0);
    stopCond();
    chk("regsWrap", regs, modelFlat());

    // Out-of-range pointer byte.
    startCond();
    writeByte(8'hEC, 1'b1, 1'b0);
    writeByte(8'h10, 1'b0, 1'b0);
    writeByte(8'h99, 1'b0, 1'b0);
    stopCond();
    chk("regsRange", regs, modelFlat());

    // SCL glitches mid-transfer, then bus/local collision on reg2.
    startCond();
    writeByte(8'hEC, 1'b1, 1'b0);
    writeByte(8'h02, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      mScl = 1'b1; clkWait(1);
      mScl = 1'b0; clkWait(3);
    end
    busWrite(4'd2, 8'h33); writeByte(8'h33, 1'b1, 1'b1);
    stopCond();
    chk("regsCollision", regs, modelFlat());

    // SCL held low after the address ACK.
    startCond();
    writeByte(8'hEC, 1'b1, 1'b0);
    clkWait(110);
`ifdef TWI_RESPONDER_TIMEOUT_EN
    chk("timeoutBusy", busy, 1'b0);
`else
    chk("stuckBusy", busy, 1'b1);
`endif
    chk("stuckSdaLow", twiBus.oSdaLow, 1'b0);
    stopCond();
    chk("busyAfterStuck", busy, 1'b0);

    // Reset while the target is pulling the address ACK.
    startCond();
    for (int i = 7; i >= 0; i--) sendBit(((8'hEC >> i) & 8'd1) != 8'd0);
    mSda = 1'b1; clkWait(Q);
    chk("ackBeforeRst", twiBus.oSdaLow, 1'b1);
    rst = 1'b1; clkWait(1);
    rst = 1'b0;
    chk("sdaAfterRst", twiBus.oSdaLow, 1'b0);
    for (int k = 0; k < 16; k++) model[k] = 8'd0;
    mScl = 1'b1; clkWait(H);
    mScl = 1'b0; clkWait(Q);
    stopCond();
    chk("regsAfterRst", regs, modelFlat());
    chk("busyAfterRst", busy, 1'b0);

    clkWait(20);
    chk("sdaQueueEmpty", sdaQ.size(), 0);
    chk("wrQueueEmpty", wrQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
